// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V controllers: opcodes, datapath selects,
// ALU control codes and the multi-cycle sequencer state set.
`timescale 1ns/1ps
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b1110;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_J = 3'b011;
    localparam logic [2:0] EXT_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_LUI,
        S_HALT
    } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from funct3/funct7_5; funct7_5 only
// selects SUB for register-register instructions.
`timescale 1ns/1ps
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_control = ALU_AND;
            3'b110:  alu_control = ALU_OR;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V sequencer with ready-based memory handshake and a
// memory-wait watchdog. Optional ILLEGAL_TRAP_EN halts on unknown opcodes.
`timescale 1ns/1ps
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       sel_adr,
    output logic       ir_we,
    output logic       pc_we,
    output logic       rf_we,
    output logic [1:0] sel_alu_src_a,
    output logic [1:0] sel_alu_src_b,
    output logic [1:0] sel_result,
    output logic [3:0] alu_control,
    output logic [2:0] sel_ext,
    output logic       retire,
    output logic       mem_err
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    state_e            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        dec_alu;
    logic              is_rtype;
    logic              wd_trip;

    assign is_rtype = (state == S_EXECR);

    // Derived from state rather than mem_req to keep next-state logic acyclic.
    assign wd_trip = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE)
                     && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT));

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .is_rtype    (is_rtype),
        .alu_control (dec_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   wait_cnt <= '0;
        else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
        else                          wait_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mem_err <= 1'b0;
        else if (wd_trip) mem_err <= 1'b1;
    end

`ifdef ILLEGAL_TRAP_EN
    // DECODE reaches HALT only through an unknown opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         illegal_instr <= 1'b0;
        else if (state == S_DECODE && state_next == S_HALT) illegal_instr <= 1'b1;
    end
`endif

    // Outputs are forced low while reset is held, even though state reads FETCH.
    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        sel_adr       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        rf_we         = 1'b0;
        sel_alu_src_a = '0;
        sel_alu_src_b = '0;
        sel_result    = '0;
        alu_control   = '0;
        sel_ext       = '0;
        retire        = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req       = 1'b1;
                    sel_alu_src_a = SRCA_PC;
                    sel_alu_src_b = SRCB_FOUR;
                    alu_control   = ALU_ADD;
                    sel_result    = RES_ALU;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    sel_alu_src_a = SRCA_OLDPC;
                    sel_alu_src_b = SRCB_IMM;
                    alu_control   = ALU_ADD;
                    case (opcode)
                        OP_LOAD:  state_next = S_MEMADR;
                        OP_STORE: begin sel_ext = EXT_S; state_next = S_MEMADR; end
                        OP_RTYPE: state_next = S_EXECR;
                        OP_ITYPE: state_next = S_EXECI;
                        OP_BEQ:   begin sel_ext = EXT_B; state_next = S_BEQ; end
                        OP_JAL:   begin sel_ext = EXT_J; state_next = S_JAL; end
                        OP_LUI:   begin sel_ext = EXT_U; state_next = S_LUI; end
`ifdef ILLEGAL_TRAP_EN
                        default:  state_next = S_HALT;
`else
                        default:  begin retire = 1'b1; state_next = S_FETCH; end
`endif
                    endcase
                end
                S_MEMADR: begin
                    sel_alu_src_a = SRCA_RD1;
                    sel_alu_src_b = SRCB_IMM;
                    alu_control   = ALU_ADD;
                    if (opcode == OP_STORE) begin
                        sel_ext    = EXT_S;
                        state_next = S_MEMWRITE;
                    end else begin
                        sel_ext    = EXT_I;
                        state_next = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    mem_req    = 1'b1;
                    sel_adr    = 1'b1;
                    sel_result = RES_ALUOUT;
                    if (mem_ready) state_next = S_MEMWB;
                end
                S_MEMWB: begin
                    sel_result = RES_DATA;
                    rf_we      = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req    = 1'b1;
                    mem_we     = 1'b1;
                    sel_adr    = 1'b1;
                    sel_result = RES_ALUOUT;
                    if (mem_ready) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_EXECR: begin
                    sel_alu_src_a = SRCA_RD1;
                    sel_alu_src_b = SRCB_RD2;
                    alu_control   = dec_alu;
                    state_next    = S_ALUWB;
                end
                S_EXECI: begin
                    sel_alu_src_a = SRCA_RD1;
                    sel_alu_src_b = SRCB_IMM;
                    sel_ext       = EXT_I;
                    alu_control   = dec_alu;
                    state_next    = S_ALUWB;
                end
                S_ALUWB: begin
                    sel_result = RES_ALUOUT;
                    rf_we      = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_BEQ: begin
                    sel_alu_src_a = SRCA_RD1;
                    sel_alu_src_b = SRCB_RD2;
                    alu_control   = ALU_SUB;
                    sel_result    = RES_ALUOUT;
                    pc_we         = zero;
                    retire        = 1'b1;
                    state_next    = S_FETCH;
                end
                S_JAL: begin
                    sel_alu_src_a = SRCA_OLDPC;
                    sel_alu_src_b = SRCB_FOUR;
                    alu_control   = ALU_ADD;
                    sel_result    = RES_ALUOUT;
                    pc_we         = 1'b1;
                    sel_ext       = EXT_J;
                    state_next    = S_ALUWB;
                end
                S_LUI: begin
                    sel_ext    = EXT_U;
                    sel_result = RES_IMM;
                    rf_we      = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_FETCH;
            endcase
            if (wd_trip) state_next = S_HALT;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected output traces built from the
// instruction class and chosen memory latencies, compared every cycle.
`timescale 1ns/1ps
module tb_multicycle_controller;

    localparam int unsigned MAX_WAIT = 15;

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_RTYPE = 7'b0110011;
    localparam logic [6:0] T_ITYPE = 7'b0010011;
    localparam logic [6:0] T_BEQ   = 7'b1100011;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, sel_adr, ir_we, pc_we, rf_we, retire, mem_err;
    logic [1:0] sel_alu_src_a, sel_alu_src_b, sel_result;
    logic [3:0] alu_control;
    logic [2:0] sel_ext;
    logic       ill_w;

    multicycle_controller #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .sel_adr       (sel_adr),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .rf_we         (rf_we),
        .sel_alu_src_a (sel_alu_src_a),
        .sel_alu_src_b (sel_alu_src_b),
        .sel_result    (sel_result),
        .alu_control   (alu_control),
        .sel_ext       (sel_ext),
        .retire        (retire),
        .mem_err       (mem_err)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_instr (ill_w)
`endif
    );

`ifndef ILLEGAL_TRAP_EN
    assign ill_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, sel_adr, ir_we, pc_we, rf_we;
        logic [1:0] src_a, src_b, res;
        logic [3:0] alu;
        logic [2:0] ext;
        logic       retire, mem_err, ill;
    } vec_t;

    typedef struct packed {
        logic rdy;
        vec_t v;
    } step_t;

    vec_t  dut_vec;
    vec_t  exp_cur;
    step_t q[$];
    bit    exp_valid = 0;
    bit    release_pending = 0;
    int    cyc = 0;
    int    retire_at = 0;
    int    checks = 0;
    int    failures = 0;

    assign dut_vec = {mem_req, mem_we, sel_adr, ir_we, pc_we, rf_we, sel_alu_src_a,
                      sel_alu_src_b, sel_result, alu_control, sel_ext, retire, mem_err, ill_w};

    function automatic logic [3:0] alu_of(logic [2:0] f3, logic f7, logic rtype);
        if (f3 == 3'b000) return (rtype && f7) ? 4'b0110 : 4'b0010;
        if (f3 == 3'b111) return 4'b1110;
        if (f3 == 3'b110) return 4'b0001;
        return 4'b0010;
    endfunction

    function automatic void push(logic rdy, vec_t v);
        q.push_back({rdy, v});
    endfunction

    function automatic logic dc();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic vec_t fetch_vec(logic rdy);
        vec_t v = '0;
        v.mem_req = 1'b1; v.src_b = 2'b10; v.alu = 4'b0010; v.res = 2'b10;
        v.ir_we = rdy; v.pc_we = rdy;
        return v;
    endfunction

    function automatic vec_t wb_vec();
        vec_t v = '0;
        v.rf_we = 1'b1; v.retire = 1'b1;
        return v;
    endfunction

    // Expected cycle-by-cycle trace of one instruction: fw fetch stalls, mw data stalls.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input int fw, input int mw);
        vec_t v;
        q.delete();
        for (int i = 0; i <= fw; i++) push(i == fw, fetch_vec(i == fw));
        v = '0; v.src_a = 2'b01; v.src_b = 2'b01; v.alu = 4'b0010;
        v.ext = (op == T_STORE) ? 3'b001 : (op == T_BEQ) ? 3'b010 :
                (op == T_JAL) ? 3'b011 : (op == T_LUI) ? 3'b100 : 3'b000;
        if (!(op inside {T_LOAD, T_STORE, T_RTYPE, T_ITYPE, T_BEQ, T_JAL, T_LUI})) begin
`ifdef ILLEGAL_TRAP_EN
            push(dc(), v);
            v = '0; v.ill = 1'b1;
            for (int i = 0; i < 3; i++) push(dc(), v);
`else
            v.retire = 1'b1;
            push(dc(), v);
`endif
            return;
        end
        push(dc(), v);
        v = '0;
        case (op)
            T_LOAD, T_STORE: begin
                v.src_a = 2'b10; v.src_b = 2'b01; v.alu = 4'b0010;
                v.ext = (op == T_STORE) ? 3'b001 : 3'b000;
                push(dc(), v);
                for (int i = 0; i <= mw; i++) begin
                    v = '0; v.mem_req = 1'b1; v.sel_adr = 1'b1;
                    v.mem_we = (op == T_STORE);
                    v.retire = (op == T_STORE) && (i == mw);
                    push(i == mw, v);
                end
                if (op == T_LOAD) begin
                    v = wb_vec(); v.res = 2'b01;
                    push(dc(), v);
                end
            end
            T_RTYPE, T_ITYPE: begin
                v.src_a = 2'b10;
                v.src_b = (op == T_ITYPE) ? 2'b01 : 2'b00;
                v.alu = alu_of(f3, f7, op == T_RTYPE);
                push(dc(), v);
                push(dc(), wb_vec());
            end
            T_BEQ: begin
                v.src_a = 2'b10; v.alu = 4'b0110; v.pc_we = z; v.retire = 1'b1;
                push(dc(), v);
            end
            T_JAL: begin
                v.src_a = 2'b01; v.src_b = 2'b10; v.alu = 4'b0010; v.pc_we = 1'b1; v.ext = 3'b011;
                push(dc(), v);
                push(dc(), wb_vec());
            end
            default: begin
                v.ext = 3'b100; v.res = 2'b11; v.rf_we = 1'b1; v.retire = 1'b1;
                push(dc(), v);
            end
        endcase
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input int limit);
        step_t s;
        int    n = 0;
        retire_at = 0;
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            s = q.pop_front();
            @(posedge clk); #1;
            if (n == 0) begin
                opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
                if (release_pending) begin
                    rst_n = 1'b1;
                    release_pending = 0;
                end
            end
            mem_ready = s.rdy;
            exp_cur   = s.v;
            exp_valid = 1;
            n++;
            cyc = n;
        end
        @(negedge clk); #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input int fw, input int mw);
        build(op, f3, f7, z, fw, mw);
        run(op, f3, f7, z, -1);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic do_reset();
        exp_valid = 0;
        #2 rst_n = 1'b0;
        #1 check_vec("reset_async", dut_vec, '0);
        repeat (2) @(posedge clk);
        #1 check_vec("reset_hold", dut_vec, '0);
        release_pending = 1;
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (dut_vec !== exp_cur) begin
                failures++;
                $display("FAIL trace cyc=%0d op=%b got=%b exp=%b", cyc, opcode, dut_vec, exp_cur);
            end
            if (retire && retire_at == 0) retire_at = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [6:0] ops[8];
        vec_t       v;
        int         fw, mw, k;
        ops = '{T_LOAD, T_STORE, T_RTYPE, T_ITYPE, T_BEQ, T_JAL, T_LUI, T_BAD};

        do_reset();

        instr(T_RTYPE, 3'b000, 1'b0, 1'b0, 0, 0);
        check_int("add_retire_cycle", retire_at, 4);
        instr(T_LOAD, 3'b010, 1'b0, 1'b0, 0, 3);
        check_int("lw_wait3_retire_cycle", retire_at, 8);
        instr(T_STORE, 3'b010, 1'b0, 1'b0, 0, 0);
        check_int("sw_retire_cycle", retire_at, 4);
        instr(T_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        check_int("beq_taken_retire_cycle", retire_at, 3);
        instr(T_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        instr(T_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        check_int("jal_retire_cycle", retire_at, 4);
        instr(T_LUI, 3'b000, 1'b0, 1'b0, 0, 0);
        check_int("lui_retire_cycle", retire_at, 3);
        instr(T_RTYPE, 3'b000, 1'b1, 1'b0, 1, 0);
        instr(T_ITYPE, 3'b000, 1'b1, 1'b0, 0, 0);
        instr(T_RTYPE, 3'b111, 1'b0, 1'b0, 0, 0);
        instr(T_ITYPE, 3'b110, 1'b0, 1'b0, 0, 0);

        // Ready arriving on the last permitted wait cycle must not trip the watchdog.
        instr(T_RTYPE, 3'b111, 1'b0, 1'b0, MAX_WAIT, 0);
        instr(T_LOAD, 3'b000, 1'b0, 1'b0, 0, MAX_WAIT);
        instr(T_STORE, 3'b000, 1'b0, 1'b0, MAX_WAIT, MAX_WAIT);

        instr(T_BAD, 3'b000, 1'b0, 1'b0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        do_reset();
`else
        check_int("illegal_nop_retire_cycle", retire_at, 2);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef ILLEGAL_TRAP_EN
            k = $urandom_range(0, 6);
`else
            k = $urandom_range(0, 7);
`endif
            fw = ($urandom_range(0, 9) == 0) ? MAX_WAIT : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? MAX_WAIT : $urandom_range(0, 3);
            instr(ops[k], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), fw, mw);
        end

        // Reset lands mid-MEMWRITE; outputs must drop without waiting for a clock.
        build(T_STORE, 3'b010, 1'b0, 1'b0, 0, 6);
        run(T_STORE, 3'b010, 1'b0, 1'b0, 5);
        check_int("memwrite_we_before_reset", mem_we, 1);
        do_reset();
        check_int("memwrite_we_after_reset", mem_we, 0);

        q.delete();
        for (int i = 0; i < 16; i++) push(1'b0, fetch_vec(1'b0));
        v = '0; v.mem_err = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b0, v);
        run(T_RTYPE, 3'b000, 1'b0, 1'b0, -1);
        check_int("watchdog_mem_err", mem_err, 1);
        do_reset();
        check_int("watchdog_err_cleared", mem_err, 0);
        instr(T_LUI, 3'b000, 1'b0, 1'b0, 0, 0);

        exp_valid = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
